// File: rtl/mrc_seq_pkg.sv
// mrc_seq_pkg: shared definitions for the skip-digit error-correcting MRC pass sequencer.
// Holds the sign encoding, the skip-index width and the sequencer FSM state type.
package mrc_seq_pkg;

  localparam int SKIP_W = 3;

  localparam logic [1:0] SGN_POS = 2'b00;
  localparam logic [1:0] SGN_NEG = 2'b01;
  localparam logic [1:0] SGN_INV = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // A pass result is legitimate only when the range bit (MSB) is clear.
  function automatic logic sgn_is_valid(input logic [1:0] s);
    return (s[1] == 1'b0);
  endfunction

endpackage

// File: rtl/mrc_sign_vote.sv
// mrc_sign_vote: combinational vote over NUM_SKIP skip-digit pass signs for one channel.
// Unanimous valid passes give a clean sign; a single surviving valid pass is a
// correction at its skip index; anything else is reported uncorrectable.
module mrc_sign_vote
  import mrc_seq_pkg::*;
#(
  parameter int NUM_SKIP = 4
) (
  input  logic [NUM_SKIP-1:0][1:0] sgn_in,
  output logic [1:0]               sgn_out,
  output logic                     corr,
  output logic                     uncorr,
  output logic [SKIP_W-1:0]        skip
);

  logic [3:0]        n_valid;
  logic              agree;
  logic [1:0]        single_sgn;
  logic [SKIP_W-1:0] single_idx;

  // Tally the valid passes, remember the last valid one, and check full agreement.
  always_comb begin
    n_valid    = '0;
    agree      = 1'b1;
    single_sgn = SGN_INV;
    single_idx = '0;
    for (int i = 0; i < NUM_SKIP; i++) begin
      if (sgn_is_valid(sgn_in[i])) begin
        n_valid    = n_valid + 4'd1;
        single_sgn = sgn_in[i];
        single_idx = SKIP_W'(i);
      end
      if (sgn_in[i] != sgn_in[0]) begin
        agree = 1'b0;
      end
    end
  end

  // Resolve the tally into the voted sign and correction status.
  always_comb begin
    sgn_out = SGN_INV;
    corr    = 1'b0;
    uncorr  = 1'b1;
    skip    = '0;
    if ((n_valid == 4'(NUM_SKIP)) && agree) begin
      sgn_out = sgn_in[0];
      uncorr  = 1'b0;
    end else if (n_valid == 4'd1) begin
      sgn_out = single_sgn;
      corr    = 1'b1;
      uncorr  = 1'b0;
      skip    = single_idx;
    end
  end

endmodule

// File: rtl/mrc_ec_pass_sequencer.sv
// mrc_ec_pass_sequencer: issues NUM_SKIP back-to-back skip-digit passes per accepted
// residue word into the no-stall MRC pipe, tracks the fixed pipe latency, captures
// the dual A/B sign returns and votes them into a corrected result.
// Optional build macro MRC_SEQ_PERF_CNT_EN adds saturating word/corr/uncorr counters.
module mrc_ec_pass_sequencer
  import mrc_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_SKIP   = 4,
  parameter int PIPE_LAT   = 6,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic [DATA_WIDTH-1:0] req_digit,
  output logic                  pipe_issue,
  output logic [SKIP_W-1:0]     pipe_skip_sel,
  output logic [DATA_WIDTH-1:0] pipe_digit,
  input  logic [1:0]            pipe_sgn_A,
  input  logic [1:0]            pipe_sgn_B,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [TAG_W-1:0]      res_tag,
  output logic [1:0]            res_sgn_A,
  output logic [1:0]            res_sgn_B,
  output logic [1:0]            res_corr,
  output logic [1:0]            res_uncorr,
  output logic [SKIP_W-1:0]     res_skip_A,
  output logic [SKIP_W-1:0]     res_skip_B
`ifdef MRC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           cnt_words,
  output logic [31:0]           cnt_corr,
  output logic [31:0]           cnt_uncorr
`endif
);

  seq_state_e                     state_q, state_d;
  logic [SKIP_W-1:0]              pass_cnt;
  logic [TAG_W-1:0]               tag_q;
  logic [PIPE_LAT-1:0]            trk_vld;
  logic [PIPE_LAT-1:0][SKIP_W-1:0] trk_skip;
  logic [NUM_SKIP-1:0][1:0]       slot_a, slot_b;
  logic [NUM_SKIP-1:0][1:0]       vote_in_a, vote_in_b;
  logic                           accept, last_pass, cap_en, last_cap, finish;
  logic [SKIP_W-1:0]              cap_idx;
  logic [1:0]                     v_sgn_a, v_sgn_b;
  logic                           v_corr_a, v_corr_b, v_uncorr_a, v_uncorr_b;
  logic [SKIP_W-1:0]              v_skip_a, v_skip_b;

  assign accept    = req_valid & req_ready;
  assign last_pass = (pass_cnt == SKIP_W'(NUM_SKIP - 1));
  assign cap_en    = trk_vld[PIPE_LAT-1];
  assign cap_idx   = trk_skip[PIPE_LAT-1];
  assign last_cap  = cap_en & (cap_idx == SKIP_W'(NUM_SKIP - 1));
  assign finish    = (state_q == ST_DRAIN) & last_cap;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept, issue every pass, drain the pipe, hold the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_ISSUE;
      ST_ISSUE: if (last_pass) state_d = ST_DRAIN;
      ST_DRAIN: if (last_cap)  state_d = ST_DONE;
      ST_DONE:  if (res_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready is forced low while reset is held.
  always_comb begin
    req_ready     = (state_q == ST_IDLE) & rst_n;
    pipe_issue    = (state_q == ST_ISSUE);
    pipe_skip_sel = (state_q == ST_ISSUE) ? pass_cnt : '0;
    res_valid     = (state_q == ST_DONE);
  end

  // Request capture and pass counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      pipe_digit <= '0;
      pass_cnt   <= '0;
    end else if (accept) begin
      tag_q      <= req_tag;
      pipe_digit <= req_digit;
      pass_cnt   <= '0;
    end else if (state_q == ST_ISSUE) begin
      pass_cnt   <= pass_cnt + SKIP_W'(1);
    end
  end

  // Latency tracker: each issued pass reappears PIPE_LAT cycles later with its skip index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld  <= '0;
      trk_skip <= '0;
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        trk_vld[i]  <= trk_vld[i-1];
        trk_skip[i] <= trk_skip[i-1];
      end
      trk_vld[0]  <= pipe_issue;
      trk_skip[0] <= pipe_skip_sel;
    end
  end

  // Merge the returning sign into its slot so the vote sees a capture in the same cycle.
  always_comb begin
    vote_in_a = slot_a;
    vote_in_b = slot_b;
    for (int i = 0; i < NUM_SKIP; i++) begin
      if (cap_en && (cap_idx == SKIP_W'(i))) begin
        vote_in_a[i] = pipe_sgn_A;
        vote_in_b[i] = pipe_sgn_B;
      end
    end
  end

  // Sign slots, one per skip index, updated when a tracked pass emerges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_a <= '0;
      slot_b <= '0;
    end else begin
      slot_a <= vote_in_a;
      slot_b <= vote_in_b;
    end
  end

  mrc_sign_vote #(.NUM_SKIP(NUM_SKIP)) u_vote_a (
    .sgn_in  (vote_in_a),
    .sgn_out (v_sgn_a),
    .corr    (v_corr_a),
    .uncorr  (v_uncorr_a),
    .skip    (v_skip_a)
  );

  mrc_sign_vote #(.NUM_SKIP(NUM_SKIP)) u_vote_b (
    .sgn_in  (vote_in_b),
    .sgn_out (v_sgn_b),
    .corr    (v_corr_b),
    .uncorr  (v_uncorr_b),
    .skip    (v_skip_b)
  );

  // Result registers, loaded once on entry to DONE and held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_tag    <= '0;
      res_sgn_A  <= '0;
      res_sgn_B  <= '0;
      res_corr   <= '0;
      res_uncorr <= '0;
      res_skip_A <= '0;
      res_skip_B <= '0;
    end else if (finish) begin
      res_tag    <= tag_q;
      res_sgn_A  <= v_sgn_a;
      res_sgn_B  <= v_sgn_b;
      res_corr   <= {v_corr_b, v_corr_a};
      res_uncorr <= {v_uncorr_b, v_uncorr_a};
      res_skip_A <= v_skip_a;
      res_skip_B <= v_skip_b;
    end
  end

`ifdef MRC_SEQ_PERF_CNT_EN
  // Saturating performance counters advanced on each result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_words  <= '0;
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (res_valid && res_ready) begin
      if (cnt_words != '1)                    cnt_words  <= cnt_words + 32'd1;
      if ((|res_corr) && (cnt_corr != '1))     cnt_corr   <= cnt_corr + 32'd1;
      if ((|res_uncorr) && (cnt_uncorr != '1)) cnt_uncorr <= cnt_uncorr + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mrc_ec_pass_sequencer.sv
// tb_mrc_ec_pass_sequencer: self-checking bench for the MRC pass sequencer.
// The bench plays the role of the fixed-latency MRC pipe and keeps a
// spec-level vote model for the expected results.
module tb_mrc_ec_pass_sequencer;

  localparam int DATA_WIDTH = 18;
  localparam int NUM_SKIP   = 4;
  localparam int PIPE_LAT   = 6;
  localparam int TAG_W      = 4;
  localparam int SNAP_W     = TAG_W + 14;
  localparam int LAT_EXP    = NUM_SKIP + PIPE_LAT + 1;

  typedef struct packed {
    logic [1:0] sgn;
    logic       corr;
    logic       uncorr;
    logic [2:0] skip;
  } vote_t;

  logic                  clk;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [TAG_W-1:0]      req_tag;
  logic [DATA_WIDTH-1:0] req_digit;
  logic                  pipe_issue;
  logic [2:0]            pipe_skip_sel;
  logic [DATA_WIDTH-1:0] pipe_digit;
  logic [1:0]            pipe_sgn_A;
  logic [1:0]            pipe_sgn_B;
  logic                  res_valid;
  logic                  res_ready;
  logic [TAG_W-1:0]      res_tag;
  logic [1:0]            res_sgn_A;
  logic [1:0]            res_sgn_B;
  logic [1:0]            res_corr;
  logic [1:0]            res_uncorr;
  logic [2:0]            res_skip_A;
  logic [2:0]            res_skip_B;
`ifdef MRC_SEQ_PERF_CNT_EN
  logic [31:0]           cnt_words;
  logic [31:0]           cnt_corr;
  logic [31:0]           cnt_uncorr;
`endif

  int vectors;
  int miscompares;
  int cyc;

  logic [1:0] cur_a [NUM_SKIP];
  logic [1:0] cur_b [NUM_SKIP];
  logic [1:0] sched_a [int];
  logic [1:0] sched_b [int];

  mrc_ec_pass_sequencer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SKIP   (NUM_SKIP),
    .PIPE_LAT   (PIPE_LAT),
    .TAG_W      (TAG_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_tag       (req_tag),
    .req_digit     (req_digit),
    .pipe_issue    (pipe_issue),
    .pipe_skip_sel (pipe_skip_sel),
    .pipe_digit    (pipe_digit),
    .pipe_sgn_A    (pipe_sgn_A),
    .pipe_sgn_B    (pipe_sgn_B),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_tag       (res_tag),
    .res_sgn_A     (res_sgn_A),
    .res_sgn_B     (res_sgn_B),
    .res_corr      (res_corr),
    .res_uncorr    (res_uncorr),
    .res_skip_A    (res_skip_A),
    .res_skip_B    (res_skip_B)
`ifdef MRC_SEQ_PERF_CNT_EN
    ,
    .cnt_words     (cnt_words),
    .cnt_corr      (cnt_corr),
    .cnt_uncorr    (cnt_uncorr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if something wedges the whole run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference vote written directly from the sign rules.
  function automatic vote_t ref_vote(input logic [1:0] s [NUM_SKIP]);
    int    good[$];
    vote_t r;
    bit    same;
    same = 1'b1;
    for (int i = 0; i < NUM_SKIP; i++) begin
      if (s[i] inside {2'b00, 2'b01}) good.push_back(i);
      if (s[i] != s[0]) same = 1'b0;
    end
    r = '{sgn: 2'b10, corr: 1'b0, uncorr: 1'b1, skip: 3'd0};
    if (good.size() == NUM_SKIP && same)
      r = '{sgn: s[0], corr: 1'b0, uncorr: 1'b0, skip: 3'd0};
    else if (good.size() == 1)
      r = '{sgn: s[good[0]], corr: 1'b1, uncorr: 1'b0, skip: 3'(good[0])};
    return r;
  endfunction

  function automatic logic [SNAP_W-1:0] exp_snap(input logic [TAG_W-1:0] tag,
                                                 input vote_t va, input vote_t vb);
    return {tag, va.sgn, vb.sgn, vb.corr, va.corr, vb.uncorr, va.uncorr, va.skip, vb.skip};
  endfunction

  function automatic logic [SNAP_W-1:0] dut_snap();
    return {res_tag, res_sgn_A, res_sgn_B, res_corr, res_uncorr, res_skip_A, res_skip_B};
  endfunction

  // One clock: advance, then act as the pipe (return scheduled signs, record new issues).
  task automatic run_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (sched_a.exists(cyc)) begin
      pipe_sgn_A = sched_a[cyc];
      pipe_sgn_B = sched_b[cyc];
      sched_a.delete(cyc);
      sched_b.delete(cyc);
    end else begin
      pipe_sgn_A = 2'($urandom);
      pipe_sgn_B = 2'($urandom);
    end
    if (pipe_issue === 1'b1) begin
      sched_a[cyc + PIPE_LAT] = cur_a[int'(pipe_skip_sel) % NUM_SKIP];
      sched_b[cyc + PIPE_LAT] = cur_b[int'(pipe_skip_sel) % NUM_SKIP];
    end
  endtask

  // Present a word and step through its accept edge; returns in cycle 1 after accept.
  task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic [DATA_WIDTH-1:0] digit,
                               output bit acc_ok);
    int n;
    n = 0;
    req_tag   = tag;
    req_digit = digit;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 50) begin
      run_cycle();
      n++;
    end
    acc_ok = (req_ready === 1'b1);
    run_cycle();
    req_valid = 1'b0;
    req_tag   = TAG_W'($urandom);
    req_digit = DATA_WIDTH'($urandom);
  endtask

  // Step until res_valid, counting cycles since the accept edge.
  task automatic await_result(input int start, output int lat);
    lat = start;
    while (res_valid !== 1'b1 && lat < 60) begin
      run_cycle();
      lat++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    run_cycle();
    res_ready = 1'b0;
  endtask

  task automatic gen_table(output logic [1:0] t [NUM_SKIP]);
    int         mode, j;
    logic [1:0] common;
    mode   = $urandom_range(0, 3);
    j      = $urandom_range(0, NUM_SKIP - 1);
    common = 2'($urandom_range(0, 1));
    for (int i = 0; i < NUM_SKIP; i++) begin
      case (mode)
        0: t[i] = common;
        1: t[i] = (i == j) ? common : {1'b1, 1'($urandom)};
        2: t[i] = 2'($urandom);
        default: t[i] = (i == j) ? (common ^ 2'b01) : common;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run_cycle();
    run_cycle();
    vectors++;
    if ({req_ready, pipe_issue, pipe_skip_sel, pipe_digit, res_valid, dut_snap()} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got rdy=%b iss=%b snap=%h, expected all zero",
               req_ready, pipe_issue, dut_snap());
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({req_ready, pipe_issue, res_valid} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got rdy/iss/vld=%b, expected 100",
               {req_ready, pipe_issue, res_valid});
    end
    run_cycle();
  endtask

  task automatic test_clean();
    bit ok;
    int lat;
    cur_a = '{2'b00, 2'b00, 2'b00, 2'b00};
    cur_b = '{2'b01, 2'b01, 2'b01, 2'b01};
    res_ready = 1'b1;
    applyStimulus(4'h5, 18'h21234, ok);
    for (int k = 0; k < NUM_SKIP; k++) begin
      vectors++;
      if ({pipe_issue, pipe_skip_sel, pipe_digit} !== {1'b1, 3'(k), 18'h21234}) begin
        miscompares++;
        $display("[TB] FAIL clean_issue%0d: got iss=%b sel=%0d dig=%h, expected 1 %0d 21234",
                 k, pipe_issue, pipe_skip_sel, pipe_digit, k);
      end
      run_cycle();
    end
    vectors++;
    if (pipe_issue !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clean_issue_end: got %b, expected 0", pipe_issue);
    end
    await_result(NUM_SKIP + 1, lat);
    vectors++;
    if (!ok || lat != 11) begin
      miscompares++;
      $display("[TB] FAIL clean_latency: got %0d (accepted=%0b), expected 11", lat, ok);
    end
    vectors++;
    if (dut_snap() !== {4'h5, 2'b00, 2'b01, 2'b00, 2'b00, 3'd0, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL clean_result: got %h, expected %h", dut_snap(),
               {4'h5, 2'b00, 2'b01, 2'b00, 2'b00, 3'd0, 3'd0});
    end
    run_cycle();
    res_ready = 1'b0;
    vectors++;
    if ({res_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL clean_release: got vld/rdy=%b, expected 01", {res_valid, req_ready});
    end
  endtask

  task automatic test_corr_a();
    bit ok;
    int lat;
    cur_a = '{2'b10, 2'b10, 2'b01, 2'b10};
    cur_b = '{2'b00, 2'b00, 2'b00, 2'b00};
    applyStimulus(4'hA, 18'h00777, ok);
    await_result(1, lat);
    vectors++;
    if (!ok || lat != 11 ||
        dut_snap() !== {4'hA, 2'b01, 2'b00, 2'b01, 2'b00, 3'd2, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL corr_a: got lat=%0d snap=%h, expected lat=11 snap=%h", lat, dut_snap(),
               {4'hA, 2'b01, 2'b00, 2'b01, 2'b00, 3'd2, 3'd0});
    end
    consume();
  endtask

  task automatic test_uncorr_b();
    bit ok;
    int lat;
    cur_a = '{2'b00, 2'b00, 2'b00, 2'b00};
    cur_b = '{2'b00, 2'b01, 2'b00, 2'b00};
    applyStimulus(4'h3, 18'h3FFFF, ok);
    await_result(1, lat);
    vectors++;
    if (!ok || lat != 11 ||
        dut_snap() !== {4'h3, 2'b00, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL uncorr_b: got lat=%0d snap=%h, expected lat=11 snap=%h", lat, dut_snap(),
               {4'h3, 2'b00, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0});
    end
    consume();
  endtask

  task automatic test_back_to_back();
    bit                ok;
    int                lat;
    logic [SNAP_W-1:0] s0;
    cur_a = '{2'b01, 2'b01, 2'b01, 2'b01};
    cur_b = '{2'b11, 2'b00, 2'b10, 2'b11};
    applyStimulus(4'h9, 18'h12345, ok);
    await_result(1, lat);
    s0 = dut_snap();
    vectors++;
    if (!ok || s0 !== {4'h9, 2'b01, 2'b00, 2'b10, 2'b00, 3'd0, 3'd1}) begin
      miscompares++;
      $display("[TB] FAIL hold_first: got %h, expected %h", s0,
               {4'h9, 2'b01, 2'b00, 2'b10, 2'b00, 3'd0, 3'd1});
    end
    req_tag   = 4'hC;
    req_digit = 18'h0ABCD;
    req_valid = 1'b1;
    for (int h = 0; h < 5; h++) begin
      run_cycle();
      vectors++;
      if ({res_valid, req_ready, dut_snap()} !== {1'b1, 1'b0, s0}) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: got vld=%b rdy=%b snap=%h, expected 1 0 %h",
                 h, res_valid, req_ready, dut_snap(), s0);
      end
    end
    consume();
    vectors++;
    if ({res_valid, req_ready, pipe_issue} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL gap_cycle: got vld/rdy/iss=%b, expected 010",
               {res_valid, req_ready, pipe_issue});
    end
    run_cycle();
    req_valid = 1'b0;
    vectors++;
    if ({pipe_issue, pipe_skip_sel, pipe_digit} !== {1'b1, 3'd0, 18'h0ABCD}) begin
      miscompares++;
      $display("[TB] FAIL late_accept: got iss=%b sel=%0d dig=%h, expected 1 0 0abcd",
               pipe_issue, pipe_skip_sel, pipe_digit);
    end
    await_result(1, lat);
    vectors++;
    if (lat != 11 || dut_snap() !== {4'hC, 2'b01, 2'b00, 2'b10, 2'b00, 3'd0, 3'd1}) begin
      miscompares++;
      $display("[TB] FAIL second_word: got lat=%0d snap=%h, expected lat=11 snap=%h", lat,
               dut_snap(), {4'hC, 2'b01, 2'b00, 2'b10, 2'b00, 3'd0, 3'd1});
    end
    consume();
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    bit spurious;
    int lat;
    cur_a = '{2'b01, 2'b01, 2'b01, 2'b01};
    cur_b = '{2'b01, 2'b01, 2'b01, 2'b01};
    applyStimulus(4'h7, 18'h15555, ok);
    run_cycle();
    run_cycle();
    vectors++;
    if ({pipe_issue, pipe_skip_sel} !== {1'b1, 3'd2}) begin
      miscompares++;
      $display("[TB] FAIL mid_issue_pass: got iss=%b sel=%0d, expected 1 2", pipe_issue, pipe_skip_sel);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, pipe_issue, pipe_skip_sel, pipe_digit, res_valid, dut_snap()} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got rdy=%b iss=%b dig=%h snap=%h, expected all zero",
               req_ready, pipe_issue, pipe_digit, dut_snap());
    end
    run_cycle();
    run_cycle();
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int c = 0; c < 15; c++) begin
      run_cycle();
      if (res_valid !== 1'b0 || pipe_issue !== 1'b0) spurious = 1'b1;
    end
    vectors++;
    if (spurious) begin
      miscompares++;
      $display("[TB] FAIL late_returns: got spurious activity=1, expected 0");
    end
    cur_a = '{2'b00, 2'b00, 2'b00, 2'b00};
    cur_b = '{2'b00, 2'b00, 2'b00, 2'b00};
    applyStimulus(4'h1, 18'h00001, ok);
    await_result(1, lat);
    vectors++;
    if (!ok || lat != 11 || dut_snap() !== {4'h1, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL post_reset_word: got lat=%0d snap=%h, expected lat=11 snap=%h", lat,
               dut_snap(), {4'h1, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0});
    end
    consume();
  endtask

  task automatic test_random();
    bit                ok, stable;
    int                lat, hold;
    logic [TAG_W-1:0]  tag;
    logic [SNAP_W-1:0] want;
    for (int w = 0; w < 40; w++) begin
      gen_table(cur_a);
      gen_table(cur_b);
      tag  = TAG_W'($urandom);
      want = exp_snap(tag, ref_vote(cur_a), ref_vote(cur_b));
      applyStimulus(tag, DATA_WIDTH'($urandom), ok);
      hold      = $urandom_range(0, 3);
      res_ready = (hold == 0) ? 1'($urandom) : 1'b0;
      await_result(1, lat);
      vectors++;
      if (!ok || lat != LAT_EXP || dut_snap() !== want) begin
        miscompares++;
        $display("[TB] FAIL random_word%0d: got lat=%0d snap=%h, expected lat=%0d snap=%h",
                 w, lat, dut_snap(), LAT_EXP, want);
      end
      if (hold > 0) begin
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
          run_cycle();
          if (res_valid !== 1'b1 || req_ready !== 1'b0 || dut_snap() !== want) stable = 1'b0;
        end
        vectors++;
        if (!stable) begin
          miscompares++;
          $display("[TB] FAIL random_hold%0d: got stable=0, expected 1", w);
        end
      end
      consume();
      for (int g = $urandom_range(0, 2); g > 0; g--) run_cycle();
    end
  endtask

`ifdef MRC_SEQ_PERF_CNT_EN
  task automatic test_perf_counters();
    bit ok;
    int lat;
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
    run_cycle();
    for (int w = 0; w < 5; w++) begin
      if (w < 3) begin
        cur_a = '{2'b00, 2'b00, 2'b00, 2'b00};
        cur_b = '{2'b01, 2'b01, 2'b01, 2'b01};
      end else if (w == 3) begin
        cur_a = '{2'b10, 2'b00, 2'b11, 2'b10};
        cur_b = '{2'b01, 2'b01, 2'b01, 2'b01};
      end else begin
        cur_a = '{2'b00, 2'b00, 2'b00, 2'b00};
        cur_b = '{2'b00, 2'b10, 2'b01, 2'b00};
      end
      applyStimulus(TAG_W'(w), DATA_WIDTH'(w), ok);
      await_result(1, lat);
      consume();
    end
    vectors++;
    if ({cnt_words, cnt_corr, cnt_uncorr} !== {32'd5, 32'd1, 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL perf_counters: got words=%0d corr=%0d uncorr=%0d, expected 5 1 1",
               cnt_words, cnt_corr, cnt_uncorr);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_tag     = '0;
    req_digit   = '0;
    res_ready   = 1'b0;
    pipe_sgn_A  = 2'b00;
    pipe_sgn_B  = 2'b00;
    cur_a       = '{2'b00, 2'b00, 2'b00, 2'b00};
    cur_b       = '{2'b00, 2'b00, 2'b00, 2'b00};
    $display("[TB] starting mrc_ec_pass_sequencer bench");
    test_reset();
    test_clean();
    test_corr_a();
    test_uncorr_b();
    test_back_to_back();
    test_reset_mid_issue();
    test_random();
`ifdef MRC_SEQ_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
